// File: rtl/reg_bank_file.sv
// -----------------------------------------------------------------------------
// reg_bank_file
//
// Register file for the CPU datapath. It holds the general-purpose register
// pairs (AF, BC, DE, HL and optional extras) and the system pairs (WZ, PC, IR,
// SP, ...). It also provides a registered read port and a 16-bit inc/dec path
// with a registered zero flag.
//
// Bank exchanges (EXX, EX AF, EX DE,HL) only flip mapping bits. Data is never
// copied.
//
// Optional feature, macro REG_BANK_SHADOW_EN:
//   defined   - a shadow bank of NGP pairs is built and the exchanges act.
//   undefined - a single bank is built and the ex_* inputs are ignored.
//
// Ports:
//   clk        in   rising-edge clock
//   nreset     in   asynchronous active-low reset
//   wr_sel     in   write pair index
//   wr_we_hi   in   write enable, high byte
//   wr_we_lo   in   write enable, low byte
//   wr_data    in   write data, high byte in [2*DW-1:DW]
//   rd_en      in   read request
//   rd_sel     in   read pair index
//   rd_data    out  registered read data (held while rd_en = 0)
//   rd_valid   out  high the cycle after an accepted rd_en
//   inc_en     in   inc/dec request
//   inc_sel    in   pair to inc/dec
//   inc_dec    in   0 = +1, 1 = -1
//   inc_zero   out  registered; last inc/dec result was zero
//   ex_all     in   EXX: toggle the bank of pairs 1..NGP-1
//   ex_af      in   toggle the bank of pair 0
//   ex_de_hl   in   toggle the DE/HL swap bit of the active bank
// -----------------------------------------------------------------------------
module reg_bank_file #(
    parameter int DW   = 8,
    parameter int NGP  = 4,
    parameter int NSYS = 4,
    parameter int AW   = $clog2(NGP + NSYS)
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [AW-1:0]   wr_sel,
    input  logic            wr_we_hi,
    input  logic            wr_we_lo,
    input  logic [2*DW-1:0] wr_data,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_sel,
    output logic [2*DW-1:0] rd_data,
    output logic            rd_valid,
    input  logic            inc_en,
    input  logic [AW-1:0]   inc_sel,
    input  logic            inc_dec,
    output logic            inc_zero,
    input  logic            ex_all,
    input  logic            ex_af,
    input  logic            ex_de_hl
);

    localparam int PWD = 2 * DW;
`ifdef REG_BANK_SHADOW_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    // Physical layout: bank 0 GP pairs, then bank 1 GP pairs (if built),
    // then the system pairs.
    localparam int NPHYS = NB * NGP + NSYS;
    localparam int PW    = $clog2(NPHYS);
    localparam logic [PWD-1:0] ONE = PWD'(1);

    typedef struct packed {
        logic          valid;
        logic [PW-1:0] idx;
    } loc_t;

    logic [PWD-1:0] mem [NPHYS];

    logic       bank_af;
    logic       bank_gp;
    logic [1:0] swap;

    loc_t           wr_loc, rd_loc, inc_loc;
    logic           wr_hit, inc_hit;
    logic [PWD-1:0] inc_res;
    logic [PWD-1:0] rd_next;

    // Translate a logical pair index into a physical storage slot using the
    // current (pre-edge) mapping bits. Out-of-range indices come back
    // invalid and point at slot 0, which is never used for them.
    function automatic loc_t map_idx(input logic [AW-1:0] sel,
                                     input logic          baf,
                                     input logic          bgp,
                                     input logic [1:0]    sw);
        loc_t r;
        int   i;
        int   p;
        i       = int'(sel);
        p       = 0;
        r.valid = 1'b1;
        if (i < NGP) begin
            if (i == 0) begin
                p = baf ? NGP : 0;
            end else if (((i == 2) || (i == 3)) && sw[bgp]) begin
                p = (bgp ? NGP : 0) + (i ^ 1);
            end else begin
                p = (bgp ? NGP : 0) + i;
            end
        end else if (i < NGP + NSYS) begin
            p = NB * NGP + (i - NGP);
        end else begin
            r.valid = 1'b0;
        end
        r.idx = PW'(p);
        return r;
    endfunction

    // NOTE: every signal driven here gets a value on every path, starting
    // with an unconditional default, so no latch can be inferred.
    always_comb begin
        wr_loc  = map_idx(wr_sel,  bank_af, bank_gp, swap);
        rd_loc  = map_idx(rd_sel,  bank_af, bank_gp, swap);
        inc_loc = map_idx(inc_sel, bank_af, bank_gp, swap);

        wr_hit  = (wr_we_hi || wr_we_lo) && wr_loc.valid;
        inc_hit = inc_en && inc_loc.valid;
        inc_res = inc_dec ? (mem[inc_loc.idx] - ONE) : (mem[inc_loc.idx] + ONE);

        // Write-first read: an inc/dec of the same slot is seen first,
        // then each enabled write byte overrides it.
        rd_next = mem[rd_loc.idx];
        if (inc_hit && (inc_loc.idx == rd_loc.idx)) begin
            rd_next = inc_res;
        end
        if (wr_hit && (wr_loc.idx == rd_loc.idx)) begin
            if (wr_we_hi) rd_next[PWD-1:DW] = wr_data[PWD-1:DW];
            if (wr_we_lo) rd_next[DW-1:0]   = wr_data[DW-1:0];
        end
        if (!rd_loc.valid) begin
            rd_next = '0;
        end
    end

    // NOTE: the register array is cleared by the asynchronous reset because
    // every pair must read zero after reset; that costs a reset net per
    // flop, so storage like this is normally left unreset unless required.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < NPHYS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // A write to the same slot comes later in this block and so
            // overrides the inc/dec result byte by byte.
            if (inc_hit) begin
                mem[inc_loc.idx] <= inc_res;
            end
            if (wr_hit && wr_we_hi) begin
                mem[wr_loc.idx][PWD-1:DW] <= wr_data[PWD-1:DW];
            end
            if (wr_hit && wr_we_lo) begin
                mem[wr_loc.idx][DW-1:0] <= wr_data[DW-1:0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every process
    // samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            inc_zero <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_next;
            end
            if (inc_hit) begin
                inc_zero <= (inc_res == '0);
            end
        end
    end

`ifdef REG_BANK_SHADOW_EN
    // swap is indexed with the pre-edge bank_gp, so an ex_de_hl that arrives
    // together with ex_all acts on the bank being left.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            bank_af <= 1'b0;
            bank_gp <= 1'b0;
            swap    <= 2'b00;
        end else begin
            bank_af <= bank_af ^ ex_af;
            bank_gp <= bank_gp ^ ex_all;
            if (ex_de_hl) begin
                swap[bank_gp] <= ~swap[bank_gp];
            end
        end
    end
`else
    assign bank_af = 1'b0;
    assign bank_gp = 1'b0;
    assign swap    = 2'b00;

    logic unused_ex;
    assign unused_ex = ex_all ^ ex_af ^ ex_de_hl;
`endif

endmodule
